// File: rtl/mic_pkg.sv
// mic_pkg: shared constants and types for the microphone capture chain
package mic_pkg;

    localparam int PCM_W         = 19;
    localparam int CIC_ORDER     = 3;
    localparam int CIC_DECIM     = 64;
    localparam int PCM_OFFSET    = 1 << 17;
    localparam int PRIME_OUTPUTS = 2;

    typedef logic signed [PCM_W-1:0] pcm_t;

    typedef enum logic {
        PRIME,
        RUN
    } cic_state_t;

endpackage

// File: rtl/pdm_cic_decimator_comb.sv
// cic_comb_stage: one registered CIC differentiator (M=1), modulo 2^PCM_W
module cic_comb_stage
    import mic_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid_in,
    input  pcm_t x,
    output pcm_t y,
    output logic valid_out
);

    pcm_t x_prev;

    // Subtract the previous decimated input; valid follows the data by one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_prev    <= '0;
            y         <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= en && valid_in;
            if (en && valid_in) begin
                y      <= x - x_prev;
                x_prev <= x;
            end
        end
    end

endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: mic clock generation, PDM capture and 3rd-order CIC decimate-by-64
module pdm_cic_decimator
    import mic_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic pdm_in,
    output logic mic_clk,
    output pcm_t pcm_data,
    output logic pcm_valid
);

    localparam int   DW     = $clog2(CLK_DIV);
    localparam int   HALF   = CLK_DIV / 2;
    localparam int   DECW   = $clog2(CIC_DECIM);
    localparam int   PW     = $clog2(PRIME_OUTPUTS + 1);
    localparam pcm_t OFFSET = pcm_t'(PCM_OFFSET);

    logic [DW-1:0]   div_cnt;
    logic [DECW-1:0] dec_cnt;
    logic [PW-1:0]   prime_cnt, prime_cnt_n;
    logic            smp_en, smp_d, pdm_r, wrap_d, comb_v;
    pcm_t            i1, i2, i3, i1_n, i2_n, i3_n, comb_in;
    pcm_t            cy [CIC_ORDER];
    logic            cv [CIC_ORDER];
    cic_state_t      state, state_n;

    assign smp_en = div_cnt == DW'(HALF - 1);

    // Free-running divider; mic_clk is high for the first half of each period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            mic_clk <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + 1'b1;
            mic_clk <= div_cnt < DW'(HALF);
        end
    end

    // Capture the PDM bit on the last high cycle and flag the integrator update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pdm_r <= 1'b0;
            smp_d <= 1'b0;
        end else begin
            smp_d <= smp_en;
            if (smp_en) pdm_r <= pdm_in;
        end
    end

    // Cascaded integrator sums; wrap-around is deliberate and cancelled by the combs
    always_comb begin
        i1_n = i1 + PCM_W'(pdm_r);
        i2_n = i2 + i1_n;
        i3_n = i3 + i2_n;
    end

    // Integrator state and decimation count advance once per PDM sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1      <= '0;
            i2      <= '0;
            i3      <= '0;
            dec_cnt <= '0;
            wrap_d  <= 1'b0;
        end else begin
            wrap_d <= smp_d && (dec_cnt == DECW'(CIC_DECIM - 1));
            if (smp_d) begin
                i1      <= i1_n;
                i2      <= i2_n;
                i3      <= i3_n;
                dec_cnt <= dec_cnt + 1'b1;
            end
        end
    end

    // Latch the last integrator one clock after the 64th update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comb_in <= '0;
            comb_v  <= 1'b0;
        end else begin
            comb_v <= wrap_d;
            if (wrap_d) comb_in <= i3;
        end
    end

    for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
        if (g == 0) begin : g_first
            cic_comb_stage u_stage (
                .clk(clk), .rst(rst), .en(1'b1),
                .valid_in(comb_v), .x(comb_in),
                .y(cy[g]), .valid_out(cv[g])
            );
        end else begin : g_rest
            cic_comb_stage u_stage (
                .clk(clk), .rst(rst), .en(1'b1),
                .valid_in(cv[g-1]), .x(cy[g-1]),
                .y(cy[g]), .valid_out(cv[g])
            );
        end
    end

    // Priming state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PRIME;
            prime_cnt <= '0;
        end else begin
            state     <= state_n;
            prime_cnt <= prime_cnt_n;
        end
    end

    // Count the suppressed start-up outputs, then run for good
    always_comb begin
        state_n     = state;
        prime_cnt_n = prime_cnt;
        if (state == PRIME && cv[CIC_ORDER-1]) begin
            prime_cnt_n = prime_cnt + 1'b1;
            state_n     = (prime_cnt == PW'(PRIME_OUTPUTS - 1)) ? RUN : PRIME;
        end
    end

    // Re-centre the unsigned comb result and emit it only once primed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
        end else begin
            pcm_valid <= cv[CIC_ORDER-1] && state == RUN;
            if (cv[CIC_ORDER-1] && state == RUN) pcm_data <= cy[CIC_ORDER-1] - OFFSET;
        end
    end

endmodule
